hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard controller for the 5-stage core. Tracks destination registers of instructions in EX, MEM and WB, and drives the pipeline-register stall, bubble, flush and freeze controls. Also generates registered forwarding selects for the EX-stage operand muxes. Sits beside the opcode decoder and reads ID-stage instruction fields plus EX/MEM status.

## Interface
Parameters:
- REG_W, 4, register-address width
- MEM_TIMEOUT, 15, consecutive mem_ready-low cycles before mem_err sets

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  4  ID-stage opcode
- id_rs1, id_rs2, id_rd  in  REG_W each  ID-stage source and destination register fields
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID register
- bubble_idex  out  1  load NOP into ID/EX
- flush_ifid  out  1  clear IF/ID register to NOP
- freeze  out  1  hold every pipeline register
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 EX/MEM result, 11 MEM/WB result, 01 reserved/never driven
- mem_err  out  1  sticky memory-timeout flag

## Operation
- Decode, combinational inside the block:
  - Register writers: 0000–0011, 1000, 1001, 1011, 1100.
  - Load: 1001.
  - Branches: 0100–0111.
  - 1010 (str) is not a writer.
  - 1101–1111 are NOPs: no write, no hazard check.
- Scoreboard: per stage (EX, MEM, WB), holds valid, rd, writes and is_load.
  - Advance when freeze=0: WB←MEM, MEM←EX, EX←ID entry.
  - The EX entry becomes invalid when bubble_idex, flush or !id_valid.
- FSM states:
  - RUN: normal operation.
  - LDSTALL: one cycle; entered on load-use.
  - FLUSH: one cycle; entered on ex_branch_taken.
  - MEMWAIT: entered when the MEM entry is a load or str and mem_ready=0; exit when mem_ready=1.
- Priority when events coincide: MEMWAIT > FLUSH > LDSTALL.
- Load-use stall:
  - Condition: ID reads rs1 or rs2 equal to the EX entry rd, the EX entry is a valid load, and id_valid=1.
  - Action: stall_pc, stall_ifid and bubble_idex high for exactly one cycle.
  - The dependent instruction then gets fwd=11.
- Branch flush: on ex_branch_taken (not frozen), assert flush_ifid and bubble_idex for one cycle; any concurrent load-use stall is discarded.
- Freeze: freeze=stall_pc=stall_ifid=1 every cycle while in MEMWAIT; the scoreboard holds.
- Forwarding, per source operand:
  - Match on a valid writer EX entry (non-load) → 10.
  - Else match on a valid writer MEM entry → 11.
  - Else → 00.
  - WB matches need no forwarding; the register file is write-through.
  - The result is registered on the edge the instruction enters EX. It holds during freeze and is 00 for a bubble.
- Memory timeout:
  - The counter increments each MEMWAIT cycle and clears on exit.
  - Reaching MEM_TIMEOUT sets mem_err. It clears only on reset. The FSM stays in MEMWAIT.

## Timing
- Reset (rst_n=0 at the edge):
  - All outputs 0, state RUN, scoreboard invalid, counter 0.
  - Reset mid-stall or mid-freeze aborts immediately.
- Output types:
  - Control outputs are combinational from state and scoreboard, decided in the same cycle as the hazard.
  - fwd_a/fwd_b are registered with 1-cycle latency from ID.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed instructions.
- ex_branch_taken during MEMWAIT is ignored; the branch unit re-asserts it after release.
- rs1==rs2 hitting the same entry drives identical selects on both operands.

## Configuration
- HAZARD_FWD_EN defined: forwarding operates as above.
- HAZARD_FWD_EN undefined:
  - fwd_a/fwd_b are tied 00.
  - Any ID source matching a valid writer in EX or MEM triggers LDSTALL.
  - LDSTALL then repeats each cycle until no such match remains (up to 2 bubbles).

## Structure
- Shared package cpu_pkg holds the opcode enum (with is_writer/is_load/is_branch functions), the fwd_sel_t enum and the hz_state_t enum.
- Sub-module hazard_scoreboard holds the EX/MEM/WB entries and the match logic. The FSM, timeout counter and forwarding registers live in hazard_controller.

## Test plan
- add r1 then add r2,r1 → second instr fwd_a=10, no stall. Independent instr → 00.
- ldr r3 then sub r4,r3,r5 → one cycle stall_pc=stall_ifid=bubble_idex=1, then fwd_a=11.
- ex_branch_taken=1 with a concurrent load-use → flush_ifid=bubble_idex=1 for one cycle, stall_pc=0.
- ldr in MEM, mem_ready=0 for 3 cycles → freeze=1 for 3 cycles, fwd held, resume cleanly. Same with 15 cycles → mem_err=1 and it stays set.
- Without HAZARD_FWD_EN: add r1 then add r2,r1 → 2 bubbles, fwd=00.
- rst_n=0 during MEMWAIT → next cycle all outputs 0 and state RUN. Opcode 1110 with rs=EX rd → no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, forwarding-select and hazard-state types for the 5-stage core
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
    OP_BEQ = 4'h4, OP_BNE = 4'h5, OP_BLT = 4'h6, OP_BGE = 4'h7,
    OP_MOV = 4'h8, OP_LDR = 4'h9, OP_STR = 4'ha, OP_LUI = 4'hb,
    OP_SHL = 4'hc, OP_NOP0 = 4'hd, OP_NOP1 = 4'he, OP_NOP2 = 4'hf
  } opcode_t;

  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b11} fwd_sel_t;

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MEMWAIT} hz_state_t;

  function automatic logic is_writer(opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_LDR, OP_LUI, OP_SHL};
  endfunction

  function automatic logic is_load(opcode_t op);
    return op == OP_LDR;
  endfunction

  function automatic logic is_branch(opcode_t op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
  endfunction

  function automatic logic is_mem(opcode_t op);
    return op inside {OP_LDR, OP_STR};
  endfunction

  function automatic logic is_nop(opcode_t op);
    return op inside {OP_NOP0, OP_NOP1, OP_NOP2};
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination tracking and ID source match logic
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             id_v,
  input  opcode_t          id_op,
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic [1:0]       ex_alu,
  output logic [1:0]       ex_ld,
  output logic [1:0]       mem_wr,
  output logic             mem_acc
);
  logic [2:0] v, wr, ld, ma;
  logic [REG_W-1:0] rd [3];
  logic unused_wb;

  // index 0 = EX, 1 = MEM, 2 = WB; the ID entry shifts in whenever the pipe is not frozen
  always_ff @(posedge clk)
    if (!rst_n) begin
      v  <= '0;
      wr <= '0;
      ld <= '0;
      ma <= '0;
      rd <= '{default: '0};
    end else if (adv) begin
      v  <= {v[1:0], id_v};
      wr <= {wr[1:0], is_writer(id_op)};
      ld <= {ld[1:0], is_load(id_op)};
      ma <= {ma[1:0], is_mem(id_op)};
      rd <= '{id_rd, rd[0], rd[1]};
    end

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [REG_W-1:0] r;
    assign r         = s ? id_rs2 : id_rs1;
    assign ex_alu[s] = v[0] && wr[0] && !ld[0] && rd[0] == r;
    assign ex_ld[s]  = v[0] && ld[0] && rd[0] == r;
    assign mem_wr[s] = v[1] && wr[1] && rd[1] == r;
  end

  assign mem_acc   = v[1] && ma[1];
  assign unused_wb = ^{v[2], wr[2], ld[2], ma[2], rd[2]};
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/bubble/flush/freeze and EX forwarding control (forwarding enabled by HAZARD_FWD_EN)
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  opcode_t op;
  hz_state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] ex_alu, ex_ld, mem_wr;
  logic mem_acc, chk, lu, hold, flush, stall, err;

  assign op    = opcode_t'(id_opcode);
  assign chk   = id_valid && !is_nop(op);
  assign hold  = mem_acc && !mem_ready;
`ifdef HAZARD_FWD_EN
  assign lu    = chk && |ex_ld;
`else
  assign lu    = chk && |{ex_alu, ex_ld, mem_wr};
`endif
  assign flush = ex_branch_taken && !hold;
  assign stall = lu && !hold && !flush;

  hazard_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (!hold),
    .id_v    (id_valid && !(flush || stall)),
    .id_op   (op),
    .id_rd   (id_rd),
    .id_rs1  (id_rs1),
    .id_rs2  (id_rs2),
    .ex_alu  (ex_alu),
    .ex_ld   (ex_ld),
    .mem_wr  (mem_wr),
    .mem_acc (mem_acc)
  );

  // winning event picks the next state; the timeout count runs only across a memory wait
  always_comb begin
    nxt     = hold ? MEMWAIT : flush ? FLUSH : stall ? LDSTALL : RUN;
    cnt_nxt = !hold ? '0 : state != MEMWAIT ? CW'(1) : cnt == TMO ? cnt : cnt + 1'b1;
  end

  // state, timeout counter and sticky timeout flag
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      err   <= err || cnt_nxt == TMO;
    end

  assign freeze      = rst_n && hold;
  assign stall_pc    = rst_n && (hold || stall);
  assign stall_ifid  = rst_n && (hold || stall);
  assign bubble_idex = rst_n && (flush || stall);
  assign flush_ifid  = rst_n && flush;
  assign mem_err     = err;

`ifdef HAZARD_FWD_EN
  fwd_sel_t fa, fb;

  function automatic fwd_sel_t sel(logic alu, logic mw);
    return alu ? FWD_EXMEM : mw ? FWD_MEMWB : FWD_RF;
  endfunction

  // operand selects are captured as the instruction enters EX; a bubble carries 00
  always_ff @(posedge clk)
    if (!rst_n) begin
      fa <= FWD_RF;
      fb <= FWD_RF;
    end else if (!hold) begin
      fa <= chk && !(flush || stall) ? sel(ex_alu[0], mem_wr[0]) : FWD_RF;
      fb <= chk && !(flush || stall) ? sel(ex_alu[1], mem_wr[1]) : FWD_RF;
    end

  assign fwd_a = fa;
  assign fwd_b = fb;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios plus randomized run against a pipeline reference model
module tb_hazard_controller;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int TMO = 15;

  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, ex_branch_taken = 1'b0, mem_ready = 1'b1;
  logic [3:0] id_opcode = '0, id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze, mem_err;
  logic [1:0] fwd_a, fwd_b;
  int tests = 0, fails = 0;

  wire [4:0] ctl = {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze};
  wire [3:0] fwd = {fwd_a, fwd_b};

  always #5 clk = ~clk;

  hazard_controller #(.REG_W(4), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err)
  );

  typedef struct packed {bit v; bit [3:0] op; bit [3:0] rd;} ent_t;
  ent_t pipe [3];
  int mcnt;
  bit merr;
  bit [1:0] mfa, mfb;

  function automatic bit wrf(bit [3:0] op);
    return op inside {[4'd0:4'd3], 4'd8, 4'd9, 4'd11, 4'd12};
  endfunction
  function automatic bit ldf(bit [3:0] op);
    return op == 4'd9;
  endfunction
  function automatic bit memf(bit [3:0] op);
    return op == 4'd9 || op == 4'd10;
  endfunction
  function automatic bit nopf(bit [3:0] op);
    return op >= 4'd13;
  endfunction
  function automatic bit hit(int s, bit [3:0] r);
    return pipe[s].v && wrf(pipe[s].op) && pipe[s].rd == r;
  endfunction
  function automatic bit [1:0] msel(bit [3:0] r);
    return (hit(0, r) && !ldf(pipe[0].op)) ? 2'b10 : hit(1, r) ? 2'b11 : 2'b00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    mcnt = 0;
    merr = 1'b0;
    mfa  = 2'b00;
    mfb  = 2'b00;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic put(bit v, bit [3:0] op, bit [3:0] s1, bit [3:0] s2, bit [3:0] d);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = s1;
    id_rs2    = s2;
    id_rd     = d;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    put(0, 0, 0, 0, 0);
    go();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_branch_taken = 1'b1;
    mem_ready = 1'b0;
    put(1, 9, 3, 3, 3);
    tests++;
    if (ctl !== 5'b0) begin fails++; $display("FAIL reset_ctl_low: got %b want 00000", ctl); end
    go();
    tests++;
    if ({ctl, mem_err, fwd} !== 10'b0) begin fails++; $display("FAIL reset_all_zero: got %b want 0000000000", {ctl, mem_err, fwd}); end
    rst_n = 1'b1;
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    put(0, 0, 0, 0, 0);
  endtask

`ifdef HAZARD_FWD_EN
  task automatic test_forwarding();
    do_reset();
    put(1, 0, 5, 6, 1);
    tests++;
    if (ctl !== 5'b0) begin fails++; $display("FAIL fwd_first_ctl: got %b want 00000", ctl); end
    go();
    put(1, 0, 1, 7, 2);
    tests++;
    if (ctl !== 5'b0) begin fails++; $display("FAIL fwd_no_stall: got %b want 00000", ctl); end
    go();
    tests++;
    if (fwd !== 4'b1000) begin fails++; $display("FAIL fwd_ex: got %b want 1000", fwd); end
    put(1, 0, 1, 1, 4);
    go();
    tests++;
    if (fwd !== 4'b1111) begin fails++; $display("FAIL fwd_mem_same_src: got %b want 1111", fwd); end
    put(1, 1, 8, 9, 5);
    go();
    tests++;
    if (fwd !== 4'b0000) begin fails++; $display("FAIL fwd_indep: got %b want 0000", fwd); end
  endtask

  task automatic test_load_use();
    do_reset();
    put(1, 9, 0, 0, 3);
    go();
    put(1, 1, 3, 5, 4);
    tests++;
    if (ctl !== 5'b11100) begin fails++; $display("FAIL lu_stall: got %b want 11100", ctl); end
    go();
    tests++;
    if (ctl !== 5'b0) begin fails++; $display("FAIL lu_one_bubble: got %b want 00000", ctl); end
    tests++;
    if (fwd !== 4'b0000) begin fails++; $display("FAIL lu_bubble_fwd: got %b want 0000", fwd); end
    go();
    put(0, 0, 0, 0, 0);
    tests++;
    if (fwd !== 4'b1100) begin fails++; $display("FAIL lu_fwd_mem: got %b want 1100", fwd); end
  endtask
`else
  task automatic test_nofwd();
    do_reset();
    put(1, 0, 5, 6, 1);
    go();
    put(1, 0, 1, 7, 2);
    tests++;
    if (ctl !== 5'b11100) begin fails++; $display("FAIL nf_stall1: got %b want 11100", ctl); end
    go();
    tests++;
    if (ctl !== 5'b11100) begin fails++; $display("FAIL nf_stall2: got %b want 11100", ctl); end
    go();
    tests++;
    if (ctl !== 5'b0) begin fails++; $display("FAIL nf_release: got %b want 00000", ctl); end
    go();
    put(0, 0, 0, 0, 0);
    tests++;
    if (fwd !== 4'b0000) begin fails++; $display("FAIL nf_fwd_tied: got %b want 0000", fwd); end
  endtask
`endif

  task automatic test_branch();
    do_reset();
    put(1, 9, 0, 0, 3);
    go();
    ex_branch_taken = 1'b1;
    put(1, 1, 3, 5, 4);
    tests++;
    if (ctl !== 5'b00110) begin fails++; $display("FAIL br_flush: got %b want 00110", ctl); end
    go();
    ex_branch_taken = 1'b0;
    put(0, 0, 0, 0, 0);
    tests++;
    if (ctl !== 5'b0) begin fails++; $display("FAIL br_one_cycle: got %b want 00000", ctl); end
  endtask

  task automatic test_memwait();
    bit [3:0] hold_fwd = FWD ? 4'b1100 : 4'b0000;
    do_reset();
    put(1, 0, 5, 6, 1);
    go();
    put(1, 9, 0, 0, 3);
    go();
    put(1, 0, FWD ? 4'd1 : 4'd9, 7, 5);
    go();
    mem_ready = 1'b0;
    ex_branch_taken = 1'b1;
    put(1, 1, 5, 8, 7);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (ctl !== 5'b11001) begin fails++; $display("FAIL mw_freeze[%0d]: got %b want 11001", i, ctl); end
      tests++;
      if (fwd !== hold_fwd) begin fails++; $display("FAIL mw_fwd_hold[%0d]: got %b want %b", i, fwd, hold_fwd); end
      go();
    end
    mem_ready = 1'b1;
    ex_branch_taken = 1'b0;
    #1;
    tests++;
    if (ctl !== (FWD ? 5'b0 : 5'b11100)) begin fails++; $display("FAIL mw_release: got %b want %b", ctl, FWD ? 5'b0 : 5'b11100); end
    go();
    tests++;
    if ({mem_err, fwd} !== {1'b0, FWD ? 4'b1000 : 4'b0000}) begin fails++; $display("FAIL mw_resume: got err=%b fwd=%b want err=0 fwd=%b", mem_err, fwd, FWD ? 4'b1000 : 4'b0000); end
  endtask

  task automatic test_timeout();
    do_reset();
    put(1, 9, 0, 0, 3);
    go();
    put(0, 0, 0, 0, 0);
    go();
    mem_ready = 1'b0;
    #1;
    for (int i = 1; i <= TMO; i++) begin
      tests++;
      if ({mem_err, freeze} !== 2'b01) begin fails++; $display("FAIL to_wait[%0d]: got err,freeze=%b want 01", i, {mem_err, freeze}); end
      go();
    end
    tests++;
    if ({mem_err, freeze} !== 2'b11) begin fails++; $display("FAIL to_set: got err,freeze=%b want 11", {mem_err, freeze}); end
    mem_ready = 1'b1;
    #1;
    go();
    go();
    tests++;
    if ({mem_err, freeze} !== 2'b10) begin fails++; $display("FAIL to_sticky: got err,freeze=%b want 10", {mem_err, freeze}); end
  endtask

  task automatic test_reset_memwait();
    put(1, 9, 0, 0, 3);
    go();
    put(0, 0, 0, 0, 0);
    go();
    mem_ready = 1'b0;
    #1;
    tests++;
    if (freeze !== 1'b1) begin fails++; $display("FAIL rm_freeze: got %b want 1", freeze); end
    go();
    rst_n = 1'b0;
    go();
    rst_n = 1'b1;
    #1;
    tests++;
    if ({ctl, mem_err, fwd} !== 10'b0) begin fails++; $display("FAIL rm_all_zero: got %b want 0000000000", {ctl, mem_err, fwd}); end
    mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_nop();
    do_reset();
    put(1, 9, 0, 0, 3);
    go();
    put(1, 14, 3, 3, 6);
    tests++;
    if (ctl !== 5'b0) begin fails++; $display("FAIL nop_no_stall: got %b want 00000", ctl); end
    go();
  endtask

  task automatic test_random();
    bit v, chk, lu, mw, fl, st;
    bit [3:0] op, s1, s2, d;
    bit [4:0] ec;
    bit [1:0] na, nb;
    int thr;
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      thr = 30 + 20 * ((n / 200) % 4);
      rst_n = $urandom_range(0, 99) != 0;
      v = $urandom_range(0, 9) < 8;
      op = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      s1 = 4'($urandom_range(0, 3));
      s2 = 4'($urandom_range(0, 3));
      d = 4'($urandom_range(0, 3));
      ex_branch_taken = $urandom_range(0, 19) == 0;
      mem_ready = $urandom_range(0, 99) < thr;
      put(v, op, s1, s2, d);
      chk = v && !nopf(op);
      mw = pipe[1].v && memf(pipe[1].op) && !mem_ready;
      lu = FWD ? (chk && pipe[0].v && ldf(pipe[0].op) && (pipe[0].rd == s1 || pipe[0].rd == s2))
               : (chk && (hit(0, s1) || hit(0, s2) || hit(1, s1) || hit(1, s2)));
      fl = ex_branch_taken && !mw;
      st = lu && !mw && !fl;
      ec = rst_n ? {mw || st, mw || st, fl || st, fl, mw} : 5'b0;
      tests++;
      if ({ctl, mem_err, fwd} !== {ec, merr, mfa, mfb}) begin
        fails++;
        $display("FAIL rand[%0d]: got ctl=%b err=%b fwd=%b want ctl=%b err=%b fwd=%b", n, ctl, mem_err, fwd, ec, merr, {mfa, mfb});
      end
      if (!rst_n) model_clear();
      else begin
        if (!mw) begin
          na = (FWD && chk && !(fl || st)) ? msel(s1) : 2'b00;
          nb = (FWD && chk && !(fl || st)) ? msel(s2) : 2'b00;
          mfa = na;
          mfb = nb;
          pipe[2] = pipe[1];
          pipe[1] = pipe[0];
          pipe[0] = '{v: v && !(fl || st), op: op, rd: d};
        end
        if (mw) begin
          mcnt++;
          if (mcnt >= TMO) merr = 1'b1;
        end else mcnt = 0;
      end
      go();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
`ifdef HAZARD_FWD_EN
    test_forwarding();
    test_load_use();
`else
    test_nofwd();
`endif
    test_branch();
    test_memwait();
    test_timeout();
    test_reset_memwait();
    test_nop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
